// File: rtl/bp_btb_gshare_pkg.sv
// Shared definitions for the branch predictor: PC geometry, width helper,
// the counter reset value and the saturating counter step.
// No ports.
package bp_pkg;

  localparam int PC_W       = 32;
  localparam int INSN_BYTES = 4;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Weakly not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
  function automatic int ctr_reset_val(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

  // One saturating step of a ctr_bits-wide counter.
  function automatic int sat_step(input int value, input logic up, input int ctr_bits);
    int max_val;
    max_val = (1 << ctr_bits) - 1;
    if (up) return (value >= max_val) ? value : value + 1;
    else    return (value == 0) ? 0 : value - 1;
  endfunction

endpackage

// File: rtl/bp_btb_gshare_if.sv
// Bundle between the pipeline and the branch predictor.
//   IF side : if_pc, if_is_ctrl -> pred_pc, pred_taken, pred_pht_idx
//   EX side : ex_valid, ex_pc, ex_taken, ex_target, ex_pred_pc, ex_pht_idx
//             -> mispredict, redirect_pc
//   Stats   : stat_branches, stat_mispred
// master = pipeline, slave = predictor.
interface bp_btb_gshare_if
  import bp_pkg::*;
#(
  parameter int PIDX_W = 6,
  parameter int STAT_W = 32
);

  logic [PC_W-1:0]   if_pc;
  logic              if_is_ctrl;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_taken;
  logic [PIDX_W-1:0] pred_pht_idx;

  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_taken;
  logic [PC_W-1:0]   ex_target;
  logic [PC_W-1:0]   ex_pred_pc;
  logic [PIDX_W-1:0] ex_pht_idx;
  logic              mispredict;
  logic [PC_W-1:0]   redirect_pc;

  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output if_pc, if_is_ctrl,
    input  pred_pc, pred_taken, pred_pht_idx,
    output ex_valid, ex_pc, ex_taken, ex_target, ex_pred_pc, ex_pht_idx,
    input  mispredict, redirect_pc,
    input  stat_branches, stat_mispred
  );

  modport slave (
    input  if_pc, if_is_ctrl,
    output pred_pc, pred_taken, pred_pht_idx,
    input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred_pc, ex_pht_idx,
    output mispredict, redirect_pc,
    output stat_branches, stat_mispred
  );

endinterface

// File: rtl/bp_btb_gshare_sat_counter_array.sv
// Pattern history table storage: ENTRIES saturating counters of CTR_BITS.
// Ports:
//   clk, reset : clock, synchronous active-high reset (loads weakly not-taken)
//   rd_idx     : combinational read index
//   rd_taken   : MSB of the counter at rd_idx (pre-update value)
//   wr_en      : apply one inc/dec at wr_idx on this edge
//   wr_idx     : counter to update
//   wr_up      : 1 = increment, 0 = decrement (both saturate)
module sat_counter_array
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int IDX_W    = clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_up
);

  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_reset_val(CTR_BITS));

  logic [CTR_BITS-1:0] ctr [ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (wr_en) begin
      ctr[wr_idx] <= CTR_BITS'(sat_step(int'(ctr[wr_idx]), wr_up, CTR_BITS));
    end
  end

  assign rd_taken = ctr[rd_idx][CTR_BITS-1];

endmodule

// File: rtl/bp_btb_gshare.sv
// Branch predictor: direct-mapped BTB plus gshare PHT (bimodal when
// GHR_BITS = 0). IF reads a combinational prediction; EX resolves and both
// tables, the global history and the stats are trained on the next edge.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : bp_btb_gshare_if.slave (IF lookup, EX resolve, stats);
//                its PIDX_W/STAT_W must match this module's parameters.
module bp_btb_gshare
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 32,
  parameter int PHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 6,
  parameter int STAT_W      = 32
) (
  input logic           clk,
  input logic           reset,
  bp_btb_gshare_if.slave bus
);

  localparam int OFS_W  = clog2(INSN_BYTES);
  localparam int IDX_W  = clog2(BTB_ENTRIES);
  localparam int PIDX_W = clog2(PHT_ENTRIES);
  localparam int TAG_W  = PC_W - IDX_W - OFS_W;
  localparam int GHR_W  = (GHR_BITS > 0) ? GHR_BITS : 1;

  // ---------------- BTB ----------------
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [PC_W-1:0]        btb_target [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             btb_hit;
  logic             train_taken;

  assign rd_idx  = bus.if_pc[IDX_W+OFS_W-1:OFS_W];
  assign rd_tag  = bus.if_pc[PC_W-1:IDX_W+OFS_W];
  assign wr_idx  = bus.ex_pc[IDX_W+OFS_W-1:OFS_W];
  assign wr_tag  = bus.ex_pc[PC_W-1:IDX_W+OFS_W];
  assign btb_hit = bus.if_is_ctrl && btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);

  // Taken resolves write the entry whether it hit or missed: on a hit the
  // tag is unchanged and only the target moves, on a miss it is replaced.
  assign train_taken = bus.ex_valid && bus.ex_taken;

  always_ff @(posedge clk) begin
    if (reset) btb_valid <= '0;
    else if (train_taken) btb_valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset && train_taken) begin
      btb_tag[wr_idx]    <= wr_tag;
      btb_target[wr_idx] <= bus.ex_target;
    end
  end

  // ---------------- Global history ----------------
  logic [GHR_W-1:0]  ghr;
  logic [PIDX_W-1:0] hist;

  generate
    if (GHR_BITS > 0) begin : g_ghr
      always_ff @(posedge clk) begin
        if (reset) ghr <= '0;
        else if (bus.ex_valid) ghr <= GHR_W'({ghr, bus.ex_taken});
      end
    end else begin : g_bimodal
      assign ghr = '0;
    end
  endgenerate

  always_comb begin
    hist = '0;
    hist[GHR_W-1:0] = ghr;
  end

  // ---------------- PHT ----------------
  logic [PIDX_W-1:0] pht_rd_idx;
  logic              pht_taken;

  assign pht_rd_idx = bus.if_pc[PIDX_W+OFS_W-1:OFS_W] ^ hist;

  sat_counter_array #(
    .ENTRIES  (PHT_ENTRIES),
    .CTR_BITS (CTR_BITS),
    .IDX_W    (PIDX_W)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pht_rd_idx),
    .rd_taken (pht_taken),
    .wr_en    (bus.ex_valid),
    .wr_idx   (bus.ex_pht_idx),
    .wr_up    (bus.ex_taken)
  );

  // ---------------- Lookup ----------------
  // Gating with reset keeps the prediction not-taken while the tables are
  // still being cleared (including the very first reset cycle).
  assign bus.pred_taken   = !reset && btb_hit && pht_taken;
  assign bus.pred_pc      = bus.pred_taken ? btb_target[rd_idx]
                                           : bus.if_pc + PC_W'(INSN_BYTES);
  assign bus.pred_pht_idx = pht_rd_idx;

  // ---------------- Resolve ----------------
  logic [PC_W-1:0] ex_seq_pc, correct_pc;

  assign ex_seq_pc       = bus.ex_pc + PC_W'(INSN_BYTES);
  assign correct_pc      = bus.ex_taken ? bus.ex_target : ex_seq_pc;
  assign bus.mispredict  = bus.ex_valid && (correct_pc != bus.ex_pred_pc);
  assign bus.redirect_pc = bus.ex_valid ? correct_pc : ex_seq_pc;

  // ---------------- Stats ----------------
  logic [STAT_W-1:0] n_branches, n_mispred;

  always_ff @(posedge clk) begin
    if (reset) begin
      n_branches <= '0;
      n_mispred  <= '0;
    end else if (bus.ex_valid) begin
      if (n_branches != '1) n_branches <= n_branches + 1'b1;
      if (bus.mispredict && (n_mispred != '1)) n_mispred <= n_mispred + 1'b1;
    end
  end

  assign bus.stat_branches = n_branches;
  assign bus.stat_mispred  = n_mispred;

endmodule

// File: tb/tb_bp_btb_gshare.sv
// Bench: dut0 is bimodal (GHR_BITS=0, STAT_W=32), dut1 is gshare
// (GHR_BITS=6, STAT_W=4). Both see the same stimulus.
module tb_bp_btb_gshare;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_if_pc;
  logic        s_if_is_ctrl;
  logic        s_ex_valid;
  logic [31:0] s_ex_pc;
  logic        s_ex_taken;
  logic [31:0] s_ex_target;
  logic [31:0] s_ex_pred_pc;
  logic [5:0]  s_ex_pht_idx;

  bp_btb_gshare_if #(.PIDX_W(6), .STAT_W(32)) b0 ();
  bp_btb_gshare_if #(.PIDX_W(6), .STAT_W(4))  b1 ();

  assign b0.if_pc = s_if_pc;       assign b1.if_pc = s_if_pc;
  assign b0.if_is_ctrl = s_if_is_ctrl; assign b1.if_is_ctrl = s_if_is_ctrl;
  assign b0.ex_valid = s_ex_valid; assign b1.ex_valid = s_ex_valid;
  assign b0.ex_pc = s_ex_pc;       assign b1.ex_pc = s_ex_pc;
  assign b0.ex_taken = s_ex_taken; assign b1.ex_taken = s_ex_taken;
  assign b0.ex_target = s_ex_target; assign b1.ex_target = s_ex_target;
  assign b0.ex_pred_pc = s_ex_pred_pc; assign b1.ex_pred_pc = s_ex_pred_pc;
  assign b0.ex_pht_idx = s_ex_pht_idx; assign b1.ex_pht_idx = s_ex_pht_idx;

  bp_btb_gshare #(.BTB_ENTRIES(32), .PHT_ENTRIES(64), .CTR_BITS(2),
                  .GHR_BITS(0), .STAT_W(32))
    dut0 (.clk(clk), .reset(rst), .bus(b0.slave));

  bp_btb_gshare #(.BTB_ENTRIES(32), .PHT_ENTRIES(64), .CTR_BITS(2),
                  .GHR_BITS(6), .STAT_W(4))
    dut1 (.clk(clk), .reset(rst), .bus(b1.slave));

  typedef struct {
    logic [31:0] if_pc;
    logic        if_is_ctrl;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_pc;
    logic [31:0] exp_pred_pc;
    logic        exp_taken;
    logic        exp_mispredict;
    logic [31:0] exp_redirect;
  } vec_t;

  vec_t vecs [17];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] if_pc, input logic ctrl, input logic exv,
                       input logic [31:0] ex_pc, input logic tk,
                       input logic [31:0] tgt, input logic [31:0] pp);
    s_if_pc      = if_pc;
    s_if_is_ctrl = ctrl;
    s_ex_valid   = exv;
    s_ex_pc      = ex_pc;
    s_ex_taken   = tk;
    s_ex_target  = tgt;
    s_ex_pred_pc = pp;
    s_ex_pht_idx = ex_pc[7:2];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] cap_pp;
  logic [5:0]  cap_idx;
  logic        tk;

  initial begin
    //           if_pc         ctl exv ex_pc         tk tgt    ex_pred      exp_pp        t  mp redirect
    vecs[0]  = '{32'h100,      1, 0, 32'h0,        0, 32'h0,   32'h0,       32'h104,      0, 0, 32'h4};
    vecs[1]  = '{32'h100,      1, 1, 32'h100,      1, 32'h40,  32'h104,     32'h104,      0, 1, 32'h40};
    vecs[2]  = '{32'h100,      1, 1, 32'h100,      1, 32'h40,  32'h40,      32'h40,       1, 0, 32'h40};
    vecs[3]  = '{32'h100,      1, 1, 32'h100,      1, 32'h40,  32'h40,      32'h40,       1, 0, 32'h40};
    vecs[4]  = '{32'h100,      1, 1, 32'h100,      1, 32'h40,  32'h40,      32'h40,       1, 0, 32'h40};
    vecs[5]  = '{32'h100,      1, 1, 32'h100,      0, 32'h40,  32'h40,      32'h40,       1, 1, 32'h104};
    vecs[6]  = '{32'h100,      1, 0, 32'h100,      0, 32'h0,   32'h0,       32'h40,       1, 0, 32'h104};
    vecs[7]  = '{32'h100,      0, 0, 32'h100,      0, 32'h0,   32'h0,       32'h104,      0, 0, 32'h104};
    vecs[8]  = '{32'h108,      1, 1, 32'h108,      0, 32'h0,   32'h10C,     32'h10C,      0, 0, 32'h10C};
    vecs[9]  = '{32'h108,      1, 1, 32'h108,      0, 32'h0,   32'h10C,     32'h10C,      0, 0, 32'h10C};
    vecs[10] = '{32'h108,      1, 1, 32'h108,      1, 32'h300, 32'h10C,     32'h10C,      0, 1, 32'h300};
    vecs[11] = '{32'h108,      1, 0, 32'h108,      0, 32'h0,   32'h0,       32'h10C,      0, 0, 32'h10C};
    vecs[12] = '{32'h100,      1, 1, 32'h100,      1, 32'h80,  32'h40,      32'h40,       1, 1, 32'h80};
    vecs[13] = '{32'h100,      1, 1, 32'h180,      1, 32'h200, 32'h184,     32'h80,       1, 1, 32'h200};
    vecs[14] = '{32'h100,      1, 0, 32'h180,      0, 32'h0,   32'h0,       32'h104,      0, 0, 32'h184};
    vecs[15] = '{32'h180,      1, 0, 32'hFFFFFFFC, 0, 32'h0,   32'h0,       32'h200,      1, 0, 32'h0};
    vecs[16] = '{32'hFFFFFFFC, 1, 1, 32'hFFFFFFFC, 0, 32'h0,   32'h0,       32'h0,        0, 0, 32'h0};

    drive(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_stat_branches", b0.stat_branches, 32'd0);
    chk("reset_stat_mispred",  b0.stat_mispred,  32'd0);

    // Bimodal table: training, hysteresis, saturation, aliasing, wrap.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].if_pc, vecs[i].if_is_ctrl, vecs[i].ex_valid, vecs[i].ex_pc,
            vecs[i].ex_taken, vecs[i].ex_target, vecs[i].ex_pred_pc);
      #1;
      chk($sformatf("v%0d_pred_pc", i), b0.pred_pc, vecs[i].exp_pred_pc);
      chk($sformatf("v%0d_pred_taken", i), 32'(b0.pred_taken), 32'(vecs[i].exp_taken));
      chk($sformatf("v%0d_mispredict", i), 32'(b0.mispredict), 32'(vecs[i].exp_mispredict));
      chk($sformatf("v%0d_redirect", i), b0.redirect_pc, vecs[i].exp_redirect);
      next_cycle();
    end
    s_ex_valid = 1'b0;
    #1;
    chk("stat_branches_11", b0.stat_branches, 32'd11);
    chk("stat_mispred_5",   b0.stat_mispred,  32'd5);

    // Reset asserted with an update in flight: prediction forced not-taken,
    // the update is dropped, tables and stats cleared.
    drive(32'h180, 1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 32'h104);
    rst = 1'b1;
    #1;
    chk("inrst_pred_taken", 32'(b0.pred_taken), 32'd0);
    chk("inrst_pred_pc",    b0.pred_pc, 32'h184);
    chk("inrst_mispredict", 32'(b0.mispredict), 32'd1);
    chk("inrst_redirect",   b0.redirect_pc, 32'h40);
    next_cycle();
    rst = 1'b0;
    drive(32'h180, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
    #1;
    chk("postrst_pred_pc",       b0.pred_pc, 32'h184);
    chk("postrst_stat_branches", b0.stat_branches, 32'd0);
    chk("postrst_stat_mispred",  b0.stat_mispred, 32'd0);

    // Counter comes out of reset weakly not-taken: one taken flips it.
    next_cycle();
    drive(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 32'h104);
    #1;
    chk("init_first_pred", b0.pred_pc, 32'h104);
    next_cycle();
    drive(32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
    #1;
    chk("init_second_pred", b0.pred_pc, 32'h40);

    // gshare on dut1: alternating T/N loop branch at 0x100.
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    #1;
    chk("g_reset_stat_branches", 32'(b1.stat_branches), 32'd0);
    chk("g_reset_pht_idx",       32'(b1.pred_pht_idx), 32'd0);
    for (int k = 0; k < 40; k++) begin
      tk = (k % 2 == 0);
      drive(32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
      #1;
      cap_pp  = b1.pred_pc;
      cap_idx = b1.pred_pht_idx;
      if (k >= 16) begin
        chk($sformatf("g%0d_pred_pc", k), cap_pp, tk ? 32'h40 : 32'h104);
        chk($sformatf("g%0d_pht_idx", k), 32'(cap_idx), tk ? 32'h2A : 32'h15);
      end
      next_cycle();
      s_if_pc      = 32'h100;
      s_ex_valid   = 1'b1;
      s_ex_pc      = 32'h100;
      s_ex_taken   = tk;
      s_ex_target  = 32'h40;
      s_ex_pred_pc = cap_pp;
      s_ex_pht_idx = cap_idx;
      #1;
      if (k >= 16) chk($sformatf("g%0d_mispredict", k), 32'(b1.mispredict), 32'd0);
      next_cycle();
      s_ex_valid = 1'b0;
    end
    #1;
    chk("g_stat_branches_sat", 32'(b1.stat_branches), 32'd15);
    chk("g_stat_mispred",      32'(b1.stat_mispred),  32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
